// File: rtl/if_pkg.sv
// Package: if_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (IDLE, REQ, DROP)
//   fetch_entry_t : one buffered fetch {pc, instr} at the default XLEN
//   PC_INC        : sequential PC step in bytes
package if_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Module: if_fetch_fifo
// DEPTH-entry FIFO of fetched {pc, instr} entries.
//   i_clk, i_reset_n : clock, async active-low reset
//   i_push, i_data   : write an entry (accepted when not full, or full with pop)
//   i_pop            : remove the head (ignored when empty; no empty bypass)
//   i_flush          : drop all entries; overrides push/pop of the same cycle
//   o_data           : head entry (meaningful only when !o_empty)
//   o_count          : number of entries held (0..DEPTH)
//   o_full, o_empty  : status flags
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  entry_t                   i_data,
  output entry_t                   o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  // Storage needs no reset: the head is never observed while empty.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Module: if_fetch_unit
// Instruction-fetch stage: owns the PC, issues one outstanding req/ack fetch at a
// time, buffers returned words with their PCs in a DEPTH-entry FIFO and hands them
// to decode. A redirect flushes the FIFO and discards any stale in-flight response.
// Optional build macro: IF_MISALIGN_CHK_EN -- a redirect to a non-word-aligned
// target raises sticky o_fetch_fault and halts fetching until reset. Without it
// the low two target bits are forced to zero and o_fetch_fault is tied low.
// Ports:
//   i_clk, i_reset_n           : clock, async active-low reset (sync release)
//   i_PCSrc, i_inAddr          : redirect strobe and target
//   o_mem_req, o_mem_instrAddr : fetch request; address stable while requesting
//   i_mem_ack, i_mem_instr     : one-cycle response strobe and data
//   o_instr_valid, i_instr_ready, o_instruction, o_outAddr : decode interface
//   o_fetch_fault              : misaligned-redirect flag
//   o_dbg_state                : current fetch FSM state
// Handshake: decode takes the head entry on every rising edge where
// o_instr_valid && i_instr_ready; the head and its data stay unchanged while
// o_instr_valid is high and i_instr_ready is low (unless a redirect flushes).
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_W,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_PCSrc,
  input  logic [XLEN-1:0] i_inAddr,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_instrAddr,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_instr,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_outAddr,
  output logic            o_fetch_fault,
  output fetch_state_e    o_dbg_state
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } slot_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic [XLEN-1:0] redir_target;
  logic            halted;

  slot_t           push_entry;
  slot_t           head_entry;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_flush;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_after_ack;
  logic            fifo_full;
  logic            fifo_empty;

`ifdef IF_MISALIGN_CHK_EN
  logic fault_q;

  assign redir_target = i_inAddr;
  assign halted       = fault_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fault_q <= 1'b0;
    end else if (i_PCSrc && (i_inAddr[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end

  assign o_fetch_fault = fault_q;
`else
  assign redir_target  = i_inAddr & ~XLEN'(3);
  assign halted        = 1'b0;
  assign o_fetch_fault = 1'b0;
`endif

  assign fifo_pop   = o_instr_valid && i_instr_ready;
  assign push_entry = '{pc: pc_q, instr: i_mem_instr};
  // Occupancy after an ack lands; the new request's slot must still fit.
  assign count_after_ack = fifo_count + CW'(1) - CW'(fifo_pop);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    fifo_push   = 1'b0;
    fifo_flush  = 1'b0;
    o_mem_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_PCSrc) begin
          pc_d       = redir_target;
          fifo_flush = 1'b1;
        end else if (!halted && !fifo_full) begin
          state_d = REQ;
        end
      end
      REQ: begin
        o_mem_req = 1'b1;
        if (i_PCSrc) begin
          pc_d        = redir_target;
          fifo_flush  = 1'b1;
          drop_addr_d = pc_q;
          // A same-cycle ack belongs to the old path; just drop it.
          state_d     = i_mem_ack ? IDLE : DROP;
        end else if (i_mem_ack) begin
          fifo_push = 1'b1;
          pc_d      = pc_q + XLEN'(PC_INC);
          state_d   = (count_after_ack < CW'(DEPTH)) ? REQ : IDLE;
        end
      end
      DROP: begin
        // The memory still owes a response on the old address; keep the
        // request up until it arrives, then throw the data away.
        o_mem_req = 1'b1;
        if (i_PCSrc) begin
          pc_d       = redir_target;
          fifo_flush = 1'b1;
        end
        if (i_mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  assign o_mem_instrAddr = (state_q == DROP) ? drop_addr_q : pc_q;
  assign o_dbg_state     = state_q;

  if_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (slot_t)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (fifo_push),
    .i_pop     (fifo_pop),
    .i_flush   (fifo_flush),
    .i_data    (push_entry),
    .o_data    (head_entry),
    .o_count   (fifo_count),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  assign o_instr_valid = !fifo_empty;
  assign o_instruction = o_instr_valid ? head_entry.instr : '0;
  assign o_outAddr     = o_instr_valid ? head_entry.pc    : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit. A memory responder answers fetch requests with a
// fixed address hash; a reference model predicts the delivered {pc, instr}
// stream (start at reset PC or redirect target, step by 4, stale responses
// dropped) and a monitor checks every decode handshake against it.
`timescale 1ns/1ps
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            i_PCSrc = 1'b0;
  logic [31:0]     i_inAddr = '0;
  logic            o_mem_req;
  logic [31:0]     o_mem_instrAddr;
  logic            i_mem_ack = 1'b0;
  logic [31:0]     i_mem_instr = '0;
  logic            o_instr_valid;
  logic            i_instr_ready = 1'b0;
  logic [31:0]     o_instruction;
  logic [31:0]     o_outAddr;
  logic            o_fetch_fault;
  fetch_state_e    dbg_state;

  if_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_PCSrc         (i_PCSrc),
    .i_inAddr        (i_inAddr),
    .o_mem_req       (o_mem_req),
    .o_mem_instrAddr (o_mem_instrAddr),
    .i_mem_ack       (i_mem_ack),
    .i_mem_instr     (i_mem_instr),
    .o_instr_valid   (o_instr_valid),
    .i_instr_ready   (i_instr_ready),
    .o_instruction   (o_instruction),
    .o_outAddr       (o_outAddr),
    .o_fetch_fault   (o_fetch_fault),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          delivered = 0;

  bit          pending   = 0;
  bit          pend_live = 0;
  logic [31:0] pend_addr = '0;
  int          lat       = 0;

  int          ready_mode = 0;  // 0 = never ready, 1 = always, 2 = random
  int          redir_pct  = 0;
  int          lat_max    = 0;
  bit          hold_ack   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
`ifdef IF_MISALIGN_CHK_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver: one clock of memory + redirect + ready ----------------
  task automatic step(input bit force_redir, input logic [31:0] tgt);
    bit          redir;
    bit          ack;
    bit          rdy;
    logic [31:0] t;
    @(negedge clk);
    ack = 1'b0;
    if (pending) begin
      check("req_held", 32'(o_mem_req), 32'd1);
      check("addr_stable", o_mem_instrAddr, pend_addr);
    end else if (o_mem_req) begin
      pending   = 1;
      pend_live = 1;
      pend_addr = o_mem_instrAddr;
      lat       = $urandom_range(0, lat_max);
      check("req_addr", o_mem_instrAddr, model_pc);
    end
    if (pending && !hold_ack) begin
      if (lat == 0) ack = 1'b1;
      else lat--;
    end
    redir = force_redir;
    t     = tgt;
    if (!redir && redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
      redir = 1'b1;
      t     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
`ifdef IF_MISALIGN_CHK_EN
      t[1:0] = 2'b00;
`endif
    end
    case (ready_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    i_mem_ack     = ack;
    i_mem_instr   = ack ? mem_word(pend_addr) : $urandom();
    i_PCSrc       = redir;
    i_inAddr      = redir ? t : $urandom();
    i_instr_ready = redir ? 1'b0 : rdy;
    if (ack) begin
      if (pend_live && !redir) begin
        exp_q.push_back({model_pc, mem_word(model_pc)});
        model_pc += 32'd4;
      end
      pending = 0;
    end
    if (redir) begin
      model_pc = align(t);
      exp_q.delete();
      pend_live = 0;
    end
    check("fifo_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
  endtask

  task automatic clear_model();
    pending   = 0;
    pend_live = 0;
    exp_q.delete();
    model_pc  = RESET_PC;
    i_PCSrc   = 1'b0;
    i_mem_ack = 1'b0;
    i_instr_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(o_mem_req), 32'd0);
    check({tag, "_valid"}, 32'(o_instr_valid), 32'd0);
    check({tag, "_instr"}, o_instruction, 32'd0);
    check({tag, "_pc"},    o_outAddr, 32'd0);
    check({tag, "_fault"}, 32'(o_fetch_fault), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && o_instr_valid && i_instr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL pop_unexpected: got pc 0x%08h with no entry expected", o_outAddr);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", o_outAddr, e[63:32]);
          check("out_instr", o_instruction, e[31:0]);
          delivered++;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    int d0;
    clear_model();
    #3;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Backpressure: exactly DEPTH entries buffered, then requests stop.
    ready_mode = 0; lat_max = 1;
    repeat (20) step(0, '0);
    check("bp_count", 32'(exp_q.size()), 32'(DEPTH));
    check("bp_req_low", 32'(o_mem_req), 32'd0);
    check("bp_valid", 32'(o_instr_valid), 32'd1);

    // Streaming: resumes at PC 0x10 after draining 0..0xC.
    ready_mode = 1; lat_max = 0;
    d0 = delivered;
    repeat (30) step(0, '0);
    check("stream_progress", 32'(delivered - d0 >= 12), 32'd1);

    // Quiesce: hold the memory, everything buffered must drain.
    hold_ack = 1;
    repeat (2 * DEPTH + 4) step(0, '0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(o_instr_valid), 32'd0);

    // Redirect while a fetch is in flight; response arrives 3 cycles later.
    step(1, 32'h0000_0100);
    repeat (3) step(0, '0);
    hold_ack = 0;
    repeat (20) step(0, '0);

    // Redirect and ack in the same cycle.
    hold_ack = 1;
    repeat (3) step(0, '0);
    hold_ack = 0; lat = 0;
    step(1, 32'h0000_0200);
    hold_ack = 1;
    step(0, '0);
    check("same_cyc_empty", 32'(o_instr_valid), 32'd0);
    repeat (3) step(0, '0);
    hold_ack = 0;
    repeat (10) step(0, '0);

    // PC wrap-around.
    step(1, 32'hFFFF_FFFC);
    repeat (15) step(0, '0);

    // Randomized traffic.
    ready_mode = 2; redir_pct = 6; lat_max = 3;
    repeat (1500) step(0, '0);
    redir_pct = 0;

    // Asynchronous reset while a request is up.
    ready_mode = 1; hold_ack = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, '0);
      seen = o_mem_req;
    end
    check("rst_req_seen", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    clear_model();
    hold_ack = 0; lat_max = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) step(0, '0);

`ifdef IF_MISALIGN_CHK_EN
    step(1, 32'h0000_0102);
    repeat (10) step(0, '0);
    check("fault_set", 32'(o_fetch_fault), 32'd1);
    check("fault_no_req", 32'(o_mem_req), 32'd0);
`else
    check("fault_tied", 32'(o_fetch_fault), 32'd0);
`endif

    // Final drain.
    hold_ack = 1; ready_mode = 1;
    repeat (2 * DEPTH + 4) step(0, '0);
    check("final_empty", 32'(exp_q.size()), 32'd0);
    check("final_valid", 32'(o_instr_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
